regfile_dump_reader: RTL

// Sequential reader for the 32x64 LEGv8 register file: on a start request it sweeps a

---
 rtl/regfile_dump_reader_if.sv | 29 ++
 rtl/regfile_dump_reader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader_if.sv
// Beat stream from the register dump reader to its sink.
// Carries one register value per valid/ready handshake, with its register
// number and an end-of-dump marker.
interface regfile_dump_reader_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data,
    output out_addr,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_addr,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Sequential register-file dump reader.
// On start, sweeps a contiguous wrapping range of registers two at a time
// through read ports SA/SB and streams each value out on the beat interface.
// Optional feature: define REGDUMP_CHECKSUM_EN to accumulate an XOR checksum
// of every beat of the most recent dump; otherwise checksum is tied to zero.
module regfile_dump_reader #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] SA,
  output logic [ADDR_WIDTH-1:0] SB,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  regfile_dump_reader_if.master out_if,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND_A,
    ST_SEND_B,
    ST_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0]   REG_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   REM_TWO   = (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_TWO   = ADDR_WIDTH'(2);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] sa_q, sa_d;
  logic [ADDR_WIDTH-1:0] sb_q, sb_d;
  logic [DATA_WIDTH-1:0] cap_b_q, cap_b_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  out_valid;
  logic                  hs;

  // State register and all datapath flops; reset aborts any dump in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      cap_b_q     <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      cap_b_q     <= cap_b_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state: one read cycle feeds two send beats until the count runs out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = (count == '0) ? ST_DONE : ST_READ;
      ST_READ:   state_d = ST_SEND_A;
      ST_SEND_A: if (hs) state_d = (remaining_q == REM_ONE) ? ST_DONE : ST_SEND_B;
      ST_SEND_B: if (hs) state_d = (remaining_q == REM_ONE) ? ST_DONE : ST_READ;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Handshake decode plus registered status outputs derived from next state.
  always_comb begin
    out_valid = (state_q == ST_SEND_A) || (state_q == ST_SEND_B);
    hs        = out_valid && out_if.out_ready;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  // Datapath: pointer/count bookkeeping, read-port selects and beat registers.
  // Beat fields are loaded one cycle ahead of the state that presents them so
  // they come straight from flops; without a handshake they simply hold.
  always_comb begin
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    cap_b_d     = cap_b_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d       = base;
          remaining_d = (count > REG_COUNT) ? REG_COUNT : count;
        end
      end
      ST_READ: begin
        out_data_d = A;
        cap_b_d    = B;
        out_addr_d = ptr_q;
        out_last_d = (remaining_q == REM_ONE);
      end
      ST_SEND_A: begin
        if (hs) begin
          remaining_d = remaining_q - REM_ONE;
          out_data_d  = cap_b_q;
          out_addr_d  = ptr_q + PTR_ONE;
          out_last_d  = (remaining_q == REM_TWO);
        end
      end
      ST_SEND_B: begin
        if (hs) begin
          remaining_d = remaining_q - REM_ONE;
          ptr_d       = ptr_q + PTR_TWO;
        end
      end
      default: ;
    endcase
    // Selects change only on entry to READ and hold everywhere else.
    if (state_d == ST_READ) begin
      sa_d = ptr_d;
      sb_d = ptr_d + PTR_ONE;
    end
  end

  assign SA               = sa_q;
  assign SB               = sb_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_addr  = out_addr_q;
  assign out_if.out_last  = out_last_q;
  assign out_if.out_valid = out_valid;
  assign busy             = busy_q;
  assign done             = done_q;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  // Checksum: cleared on an accepted start, folded with every accepted beat.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == ST_IDLE) && start) begin
      checksum_d = '0;
    end else if (hs) begin
      checksum_d = checksum_q ^ out_data_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
